// File: rtl/show_ascii_multi.sv
// Decimal text overlay on a 24-bit RGB pixel stream: N_SLOT values drawn from an external glyph ROM, 5-cycle latency.
// Optional macro SHOW_ASCII_BG_EN dims glyph-background pixels inside a text box to half brightness.
module show_ascii_multi #(
   parameter int          P_W      = 11,
   parameter int          IMG_W    = 640,
   parameter int          IMG_H    = 480,
   parameter int          N_SLOT   = 8,
   parameter int          DIGITS   = 3,
   parameter int          GLYPH_W  = 16,
   parameter int          GLYPH_H  = 32,
   parameter logic [23:0] FG_COLOR = 24'hFFFFFF
) (
   input  logic                                          sys_clk,
   input  logic                                          sys_rst,
   input  logic [N_SLOT*8-1:0]                           i_values,
   input  logic [N_SLOT*P_W-1:0]                         i_slot_x,
   input  logic [N_SLOT*P_W-1:0]                         i_slot_y,
   input  logic [N_SLOT-1:0]                             i_slot_en,
   input  logic                                          i_valid,
   input  logic [23:0]                                   i_data,
   output logic                                          o_valid,
   output logic [23:0]                                   o_data,
   output logic [6+$clog2(GLYPH_H)+$clog2(GLYPH_W):0]    o_rom_ad,
   input  logic                                          i_rom_dout
);

   localparam int RW = $clog2(GLYPH_H);
   localparam int CW = $clog2(GLYPH_W);
   localparam int SW = (N_SLOT > 1) ? $clog2(N_SLOT) : 1;
   localparam logic [P_W-1:0] X_LAST = P_W'(IMG_W - 1);
   localparam logic [P_W-1:0] Y_LAST = P_W'(IMG_H - 1);
   localparam logic [P_W:0]   BOX_W  = (P_W+1)'(DIGITS * GLYPH_W);
   localparam logic [P_W:0]   BOX_H  = (P_W+1)'(GLYPH_H);

   function automatic logic [11:0] to_bcd(input logic [7:0] v);
      logic [19:0] s;
      s = {12'd0, v};
      for (int i = 0; i < 8; i++) begin
         if (s[11:8]  >= 4'd5) s[11:8]  = s[11:8]  + 4'd3;
         if (s[15:12] >= 4'd5) s[15:12] = s[15:12] + 4'd3;
         if (s[19:16] >= 4'd5) s[19:16] = s[19:16] + 4'd3;
         s = s << 1;
      end
      return s[19:8];
   endfunction

   // place 2/1/0 = hundreds/tens/ones; leading zeros blank to space except the ones digit
   function automatic logic [6:0] glyph_code(input logic [7:0] v, input logic [1:0] place);
      logic [11:0] b;
      logic [6:0]  c;
      b = to_bcd(v);
      case (place)
         2'd2:    c = (b[11:8] == 4'd0) ? 7'd32 : 7'd48 + {3'd0, b[11:8]};
         2'd1:    c = (b[11:4] == 8'd0) ? 7'd32 : 7'd48 + {3'd0, b[7:4]};
         default: c = 7'd48 + {3'd0, b[3:0]};
      endcase
      return c;
   endfunction

`ifdef SHOW_ASCII_BG_EN
   function automatic logic [23:0] half_px(input logic [23:0] p);
      return {1'b0, p[23:17], 1'b0, p[15:9], 1'b0, p[7:1]};
   endfunction
`endif

   logic [P_W-1:0] x_cnt, y_cnt;
   logic           take;
   logic [7:0]     snap_val [N_SLOT];
   logic [P_W-1:0] snap_x   [N_SLOT];
   logic [P_W-1:0] snap_y   [N_SLOT];
   logic [N_SLOT-1:0] snap_en;

   logic [P_W:0]   dx_a [N_SLOT];
   logic [P_W:0]   dy_a [N_SLOT];
   logic [N_SLOT-1:0] in_box;
   logic           hit_c;
   logic [SW-1:0]  slot_c;
   logic [1:0]     dig_c;
   logic [RW-1:0]  row_c;
   logic [CW-1:0]  col_c;
   logic [6:0]     ascii_c;

   logic           hit_p1, hit_p2, hit_p3, hit_p4;
   logic [SW-1:0]  slot_p1;
   logic [1:0]     dig_p1;
   logic [RW-1:0]  row_p1;
   logic [CW-1:0]  col_p1;
   logic [23:0]    dat_p1, dat_p2, dat_p3, dat_p4;
   logic           vld_p1, vld_p2, vld_p3, vld_p4;

   // the frame's first pixel already sees the slot settings it is capturing
   assign take = i_valid && (x_cnt == '0) && (y_cnt == '0);

   always_comb begin
      in_box = '0;
      for (int k = 0; k < N_SLOT; k++) begin
         dx_a[k] = {1'b0, x_cnt} - {1'b0, (take ? i_slot_x[k*P_W +: P_W] : snap_x[k])};
         dy_a[k] = {1'b0, y_cnt} - {1'b0, (take ? i_slot_y[k*P_W +: P_W] : snap_y[k])};
         in_box[k] = (take ? i_slot_en[k] : snap_en[k]) &&
                     !dx_a[k][P_W] && (dx_a[k] < BOX_W) &&
                     !dy_a[k][P_W] && (dy_a[k] < BOX_H);
      end
   end

   always_comb begin
      hit_c  = 1'b0;
      slot_c = '0;
      dig_c  = '0;
      row_c  = '0;
      col_c  = '0;
      for (int k = N_SLOT - 1; k >= 0; k--) begin
         if (i_valid && in_box[k]) begin
            hit_c  = 1'b1;
            slot_c = SW'(k);
            dig_c  = dx_a[k][CW+1:CW];
            row_c  = dy_a[k][RW-1:0];
            col_c  = dx_a[k][CW-1:0];
         end
      end
   end

   assign ascii_c = glyph_code(snap_val[slot_p1], 2'(DIGITS - 1) - dig_p1);

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         x_cnt   <= '0;
         y_cnt   <= '0;
         snap_en <= '0;
         for (int k = 0; k < N_SLOT; k++) begin
            snap_val[k] <= '0;
            snap_x[k]   <= '0;
            snap_y[k]   <= '0;
         end
      end else if (i_valid) begin
         if (take) begin
            snap_en <= i_slot_en;
            for (int k = 0; k < N_SLOT; k++) begin
               snap_val[k] <= i_values[k*8 +: 8];
               snap_x[k]   <= i_slot_x[k*P_W +: P_W];
               snap_y[k]   <= i_slot_y[k*P_W +: P_W];
            end
         end
         if (x_cnt == X_LAST) begin
            x_cnt <= '0;
            y_cnt <= (y_cnt == Y_LAST) ? '0 : y_cnt + P_W'(1);
         end else begin
            x_cnt <= x_cnt + P_W'(1);
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         hit_p1 <= 1'b0; slot_p1 <= '0; dig_p1 <= '0; row_p1 <= '0; col_p1 <= '0;
         dat_p1 <= '0;   vld_p1  <= 1'b0;
         hit_p2 <= 1'b0; dat_p2  <= '0; vld_p2 <= 1'b0; o_rom_ad <= '0;
         hit_p3 <= 1'b0; dat_p3  <= '0; vld_p3 <= 1'b0;
         hit_p4 <= 1'b0; dat_p4  <= '0; vld_p4 <= 1'b0;
         o_valid <= 1'b0; o_data <= '0;
      end else begin
         // stage 1: hit test
         hit_p1  <= hit_c;
         slot_p1 <= slot_c;
         dig_p1  <= dig_c;
         row_p1  <= row_c;
         col_p1  <= col_c;
         dat_p1  <= i_data;
         vld_p1  <= i_valid;
         // stage 2: glyph ROM address
         o_rom_ad <= hit_p1 ? {ascii_c, row_p1, col_p1} : '0;
         hit_p2   <= hit_p1;
         dat_p2   <= dat_p1;
         vld_p2   <= vld_p1;
         // stages 3-4: cover the ROM read latency
         hit_p3 <= hit_p2;
         dat_p3 <= dat_p2;
         vld_p3 <= vld_p2;
         hit_p4 <= hit_p3;
         dat_p4 <= dat_p3;
         vld_p4 <= vld_p3;
         // stage 5: pixel merge
         o_valid <= vld_p4;
         if (hit_p4 && i_rom_dout)
            o_data <= FG_COLOR;
`ifdef SHOW_ASCII_BG_EN
         else if (hit_p4)
            o_data <= half_px(dat_p4);
`endif
         else
            o_data <= dat_p4;
      end
   end

endmodule

// File: tb/tb_show_ascii_multi.sv
// Randomised scoreboard bench for show_ascii_multi on a reduced 160x64 image with a synthetic glyph ROM.
module tb_show_ascii_multi;

   localparam int P_W = 11, IMG_W = 160, IMG_H = 64, N_SLOT = 8, DIGITS = 3;
   localparam int GW = 16, GH = 32, AW = 7 + 5 + 4;
   localparam logic [23:0] FG = 24'hFFFFFF;

   logic                  sys_clk = 1'b0;
   logic                  sys_rst = 1'b1;
   logic [N_SLOT*8-1:0]   i_values;
   logic [N_SLOT*P_W-1:0] i_slot_x, i_slot_y;
   logic [N_SLOT-1:0]     i_slot_en;
   logic                  i_valid;
   logic [23:0]           i_data;
   logic                  o_valid;
   logic [23:0]           o_data;
   logic [AW-1:0]         o_rom_ad;
   logic                  i_rom_dout;
   logic                  rom_d1;

   show_ascii_multi #(.P_W(P_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .N_SLOT(N_SLOT), .DIGITS(DIGITS),
                      .GLYPH_W(GW), .GLYPH_H(GH), .FG_COLOR(FG)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .i_values(i_values), .i_slot_x(i_slot_x),
      .i_slot_y(i_slot_y), .i_slot_en(i_slot_en), .i_valid(i_valid), .i_data(i_data),
      .o_valid(o_valid), .o_data(o_data), .o_rom_ad(o_rom_ad), .i_rom_dout(i_rom_dout));

   always #5 sys_clk = ~sys_clk;

   // synthetic font: spaces and address 0 are blank, other glyphs get a varied bit pattern
   function automatic bit font_bit(input logic [AW-1:0] ad);
      int a, r, c;
      a = int'(ad[AW-1:9]);
      r = int'(ad[8:4]);
      c = int'(ad[3:0]);
      if (a == 0 || a == 32) return 1'b0;
      return ((a + 3 * r + c) % 4) < 2;
   endfunction

   always @(posedge sys_clk) begin
      rom_d1     <= font_bit(o_rom_ad);
      i_rom_dout <= rom_d1;
   end

   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   typedef struct { int due; logic [23:0] d; }     dent_t;
   typedef struct { int due; logic [AW-1:0] a; }   rent_t;
   dent_t dq[$];
   rent_t rq[$];
   dent_t de;
   rent_t re;
   int total = 0, bad = 0;
   int idle_lo = -1, idle_hi = -2;

   int c_val[N_SLOT], c_x[N_SLOT], c_y[N_SLOT];
   bit c_en[N_SLOT];
   int s_val[N_SLOT], s_x[N_SLOT], s_y[N_SLOT];
   bit s_en[N_SLOT];
   int mx = 0, my = 0;

   task automatic apply_cfg();
      for (int k = 0; k < N_SLOT; k++) begin
         i_values[k*8 +: 8]    = 8'(c_val[k]);
         i_slot_x[k*P_W +: P_W] = P_W'(c_x[k]);
         i_slot_y[k*P_W +: P_W] = P_W'(c_y[k]);
         i_slot_en[k]          = c_en[k];
      end
   endtask

   task automatic random_cfg();
      for (int k = 0; k < N_SLOT; k++) begin
         case ($urandom_range(0, 2))
            0:       c_val[k] = int'($urandom_range(0, 9));
            1:       c_val[k] = int'($urandom_range(10, 99));
            default: c_val[k] = int'($urandom_range(100, 255));
         endcase
         c_x[k]  = int'($urandom_range(0, IMG_W + 8));
         c_y[k]  = int'($urandom_range(0, IMG_H));
         c_en[k] = ($urandom_range(0, 3) != 0);
      end
      apply_cfg();
   endtask

   // reference: text box lookup on the frame snapshot, digits built with decimal arithmetic
   function automatic void model_pixel(input int x, input int y, output bit hit,
                                       output int ch, output int row, output int col);
      int v, h, t, o, d;
      int txt[3];
      hit = 1'b0; ch = 0; row = 0; col = 0;
      for (int k = 0; k < N_SLOT; k++) begin
         if (!hit && s_en[k] && x >= s_x[k] && x < s_x[k] + DIGITS * GW &&
             y >= s_y[k] && y < s_y[k] + GH) begin
            hit = 1'b1;
            v = s_val[k];
            h = v / 100; t = (v / 10) % 10; o = v % 10;
            txt[0] = (h != 0) ? 48 + h : 32;
            txt[1] = (h != 0 || t != 0) ? 48 + t : 32;
            txt[2] = 48 + o;
            d   = (x - s_x[k]) / GW;
            ch  = txt[3 - DIGITS + d];
            row = y - s_y[k];
            col = (x - s_x[k]) % GW;
         end
      end
   endfunction

   task automatic step(input bit v, input logic [23:0] d);
      bit hit;
      int ch, row, col;
      logic [23:0]   exp_d;
      logic [AW-1:0] exp_a;
      i_valid = v;
      i_data  = d;
      exp_a   = '0;
      if (v) begin
         if (mx == 0 && my == 0) begin
            for (int k = 0; k < N_SLOT; k++) begin
               s_val[k] = c_val[k]; s_x[k] = c_x[k]; s_y[k] = c_y[k]; s_en[k] = c_en[k];
            end
         end
         model_pixel(mx, my, hit, ch, row, col);
         exp_d = d;
         if (hit) begin
            exp_a = {7'(ch), 5'(row), 4'(col)};
            if (font_bit(exp_a)) exp_d = FG;
`ifdef SHOW_ASCII_BG_EN
            else exp_d = (d >> 1) & 24'h7F7F7F;
`endif
         end
         dq.push_back('{cyc + 5, exp_d});
         if (mx == IMG_W - 1) begin
            mx = 0;
            my = (my == IMG_H - 1) ? 0 : my + 1;
         end else begin
            mx = mx + 1;
         end
      end
      rq.push_back('{cyc + 2, exp_a});
      @(posedge sys_clk); #1;
   endtask

   task automatic do_reset(input int n);
      sys_rst = 1'b1;
      i_valid = 1'b0;
      i_data  = '0;
      while (dq.size() > 0 && dq[$].due > cyc) void'(dq.pop_back());
      while (rq.size() > 0 && rq[$].due > cyc) void'(rq.pop_back());
      idle_lo = cyc + 1;
      repeat (n) begin
         rq.push_back('{cyc + 2, AW'(0)});
         @(posedge sys_clk); #1;
      end
      sys_rst = 1'b0;
      idle_hi = cyc + 4;
      mx = 0; my = 0;
      for (int k = 0; k < N_SLOT; k++) begin
         s_val[k] = 0; s_x[k] = 0; s_y[k] = 0; s_en[k] = 1'b0;
      end
   endtask

   always @(negedge sys_clk) begin
      if (cyc >= idle_lo && cyc <= idle_hi) begin
         total++;
         if (o_valid !== 1'b0 || o_data !== 24'h0 || o_rom_ad !== '0) begin
            bad++;
            $display("FAIL reset_idle cyc=%0d got v=%b d=%h ad=%h want all 0", cyc, o_valid, o_data, o_rom_ad);
         end
      end
      if (rq.size() > 0 && rq[0].due == cyc) begin
         re = rq.pop_front();
         total++;
         if (o_rom_ad !== re.a) begin
            bad++;
            $display("FAIL rom_ad cyc=%0d got %h want %h", cyc, o_rom_ad, re.a);
         end
      end
      if (o_valid === 1'b1 || (dq.size() > 0 && dq[0].due == cyc)) begin
         total++;
         if (dq.size() == 0) begin
            bad++;
            $display("FAIL unexpected_valid cyc=%0d got d=%h want no output", cyc, o_data);
         end else begin
            de = dq.pop_front();
            if (o_valid !== 1'b1 || o_data !== de.d || de.due != cyc) begin
               bad++;
               $display("FAIL pixel cyc=%0d got v=%b d=%h want v=1 d=%h at cyc=%0d",
                        cyc, o_valid, o_data, de.d, de.due);
            end
         end
      end
   end

   initial begin
      int acc;
      bit v;
      i_valid = 1'b0;
      i_data  = '0;
      for (int k = 0; k < N_SLOT; k++) begin
         c_val[k] = 0; c_x[k] = 0; c_y[k] = 0; c_en[k] = 1'b0;
      end
      apply_cfg();
      @(posedge sys_clk); #1;
      do_reset(3);
      repeat (6) step(1'b0, 24'h0);

      // frame 1: directed slots, continuous valid
      c_val[0] = 7;   c_x[0] = 32;  c_y[0] = 16; c_en[0] = 1'b1;
      c_val[1] = 255; c_x[1] = 100; c_y[1] = 24; c_en[1] = 1'b1;
      c_val[2] = 42;  c_x[2] = 110; c_y[2] = 24; c_en[2] = 1'b1;
      c_val[3] = 123; c_x[3] = 150; c_y[3] = 8;  c_en[3] = 1'b1;
      c_val[4] = 88;  c_x[4] = 170; c_y[4] = 0;  c_en[4] = 1'b1;
      c_val[5] = 9;   c_x[5] = 0;   c_y[5] = 40; c_en[5] = 1'b0;
      c_val[6] = 10;  c_x[6] = 60;  c_y[6] = 50; c_en[6] = 1'b1;
      c_val[7] = 100; c_x[7] = 4;   c_y[7] = 2;  c_en[7] = 1'b1;
      apply_cfg();
      repeat (IMG_W * IMG_H) step(1'b1, 24'($urandom));

      // frame 2: alternating valid, settings changed halfway through
      for (int i = 0; i < IMG_W * IMG_H; i++) begin
         if (i == IMG_W * IMG_H / 2) random_cfg();
         step(1'b1, 24'($urandom));
         step(1'b0, 24'($urandom));
      end

      // frame 3: random gaps
      acc = 0;
      while (acc < IMG_W * IMG_H) begin
         v = ($urandom_range(0, 3) != 0);
         step(v, 24'($urandom));
         if (v) acc++;
      end

      // frame 4: reset in the middle of the frame
      random_cfg();
      while (!(mx == 0 && my == 40)) step(1'b1, 24'($urandom));
      do_reset(1);
      repeat (3000) step($urandom_range(0, 4) != 0, 24'($urandom));
      repeat (8) step(1'b0, 24'h0);

      total++;
      if (dq.size() != 0) begin
         bad++;
         $display("FAIL drain got %0d pending pixels want 0", dq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
